jpeg_hdr_stream: RTL and testbench

Reads the pre-built JPEG header image out of the encoder's header ROM and emits it as a byte stream under valid/ready flow control. While streaming, it replaces the SOF0 height and width fields with run-time image dimensions. The block sits between the header ROM read port of the encoder memory block and the output byte mux that feeds the JPEG stream before entropy-coded data.

---
 rtl/jpeg_enc_pkg.sv | 19 +
 rtl/jpeg_fifo2.sv | 46 ++++
 rtl/jpeg_hdr_stream.sv | 129 ++++++++++++
 tb/tb_jpeg_hdr_stream.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared constants and types for the JPEG encoder header path.
// Header geometry defaults, marker codes and the header streamer FSM states.
package jpeg_enc_pkg;

    localparam int DEF_HDR_LEN = 607;
    localparam int DEF_HGT_OFS = 159;
    localparam int DEF_WID_OFS = 161;
    localparam int DEF_AW      = 10;

    localparam logic [15:0] SOI  = 16'hFFD8;
    localparam logic [15:0] SOF0 = 16'hFFC0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } hdr_state_t;

endpackage

// File: rtl/jpeg_fifo2.sv
// Two-entry FIFO of {last, data}; push and pop may happen in the same cycle.
// A push into a full FIFO is only taken when a pop frees a slot at the same edge.
module jpeg_fifo2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [8:0] din,
    input  logic       pop,
    output logic [8:0] dout,
    output logic       full,
    output logic       empty
);

    logic [8:0] m0;
    logic [8:0] m1;
    logic       wp;
    logic       rp;
    logic [1:0] cnt;
    logic       wr;
    logic       rd;

    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign wr    = push && (!full || pop);
    assign rd    = pop && !empty;
    assign dout  = rp ? m1 : m0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0  <= '0;
            m1  <= '0;
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (wr) begin
                if (wp) m1 <= din;
                else    m0 <= din;
                wp <= ~wp;
            end
            if (rd) rp <= ~rp;
            cnt <= cnt + {1'b0, wr} - {1'b0, rd};
        end
    end

endmodule

// File: rtl/jpeg_hdr_stream.sv
// Streams the header ROM out as bytes, patching SOF0 height/width on the fly.
// Reads are credit-limited so buffered plus in-flight bytes never exceed two.
module jpeg_hdr_stream
    import jpeg_enc_pkg::*;
#(
    parameter int HDR_LEN = DEF_HDR_LEN,
    parameter int HGT_OFS = DEF_HGT_OFS,
    parameter int WID_OFS = DEF_WID_OFS,
    parameter int AW      = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   img_width,
    input  logic [15:0]   img_height,
    output logic [AW-1:0] hdr_rom_a,
    input  logic [7:0]    hdr_rom_d,
    output logic [7:0]    hdr_data,
    output logic          hdr_valid,
    output logic          hdr_last,
    input  logic          hdr_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_A = AW'(HDR_LEN - 1);
    localparam logic [AW-1:0] HGT_A0 = AW'(HGT_OFS);
    localparam logic [AW-1:0] HGT_A1 = AW'(HGT_OFS + 1);
    localparam logic [AW-1:0] WID_A0 = AW'(WID_OFS);
    localparam logic [AW-1:0] WID_A1 = AW'(WID_OFS + 1);

    hdr_state_t    state;
    logic [15:0]   wid_q;
    logic [15:0]   hgt_q;
    logic [AW-1:0] nxt_a;
    logic [AW-1:0] idx2;
    logic          rd_v1;
    logic          rd_v2;
    logic          pop;
    logic          full;
    logic          empty;
    logic [1:0]    occ;
    logic [2:0]    credit;
    logic          issue;
    logic [7:0]    patched;
    logic [8:0]    head;

    assign pop       = !empty && hdr_ready;
    assign hdr_valid = !empty;
    assign hdr_data  = head[7:0];
    assign hdr_last  = !empty && head[8];

    // rd_v1: address on the ROM this cycle; rd_v2: its data is on hdr_rom_d now
    assign occ    = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
    assign credit = {1'b0, occ} + {2'b0, rd_v1} + {2'b0, rd_v2};
    assign issue  = (state == RUN) && (credit < 3'd2 + {2'b0, pop});

    always_comb begin
        patched = hdr_rom_d;
        unique case (idx2)
            HGT_A0:  patched = hgt_q[15:8];
            HGT_A1:  patched = hgt_q[7:0];
            WID_A0:  patched = wid_q[15:8];
            WID_A1:  patched = wid_q[7:0];
            default: patched = hdr_rom_d;
        endcase
    end

    jpeg_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_v2),
        .din   ({idx2 == LAST_A, patched}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hdr_rom_a <= '0;
            nxt_a     <= '0;
            idx2      <= '0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            wid_q     <= '0;
            hgt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done  <= 1'b0;
            rd_v1 <= 1'b0;
            rd_v2 <= rd_v1;
            idx2  <= hdr_rom_a;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        wid_q     <= img_width;
                        hgt_q     <= img_height;
                        busy      <= 1'b1;
                        hdr_rom_a <= '0;
                        nxt_a     <= AW'(1);
                        rd_v1     <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        hdr_rom_a <= nxt_a;
                        nxt_a     <= nxt_a + AW'(1);
                        rd_v1     <= 1'b1;
                        if (nxt_a == LAST_A) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && hdr_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_hdr_stream.sv
// Scoreboard bench for jpeg_hdr_stream: a reference header model fills the
// expected queue, a negedge monitor pops and compares every accepted byte.
module tb_jpeg_hdr_stream;
    import jpeg_enc_pkg::*;

    localparam int HL = DEF_HDR_LEN;
    localparam int HO = DEF_HGT_OFS;
    localparam int WO = DEF_WID_OFS;
    localparam int AW = DEF_AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   img_width = '0;
    logic [15:0]   img_height = '0;
    logic [AW-1:0] hdr_rom_a;
    logic [7:0]    hdr_rom_d = '0;
    logic [7:0]    hdr_data;
    logic          hdr_valid;
    logic          hdr_last;
    logic          hdr_ready = 1'b0;
    logic          busy;
    logic          done;

    logic [7:0] rom [0:(1<<AW)-1];
    logic [8:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int rdy_mode = 1;
    int acc_cnt = 0;

    jpeg_hdr_stream dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .hdr_rom_a  (hdr_rom_a),
        .hdr_rom_d  (hdr_rom_d),
        .hdr_data   (hdr_data),
        .hdr_valid  (hdr_valid),
        .hdr_last   (hdr_last),
        .hdr_ready  (hdr_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) hdr_rom_d <= rom[hdr_rom_a];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_rom(input bit rnd);
        for (int i = 0; i < (1 << AW); i++)
            rom[i] = rnd ? 8'($urandom) : 8'(i);
    endtask

    task automatic push_stream(input logic [15:0] w, input logic [15:0] h);
        logic [7:0] b;
        for (int i = 0; i < HL; i++) begin
            b = rom[i];
            if (i == HO)     b = h[15:8];
            if (i == HO + 1) b = h[7:0];
            if (i == WO)     b = w[15:8];
            if (i == WO + 1) b = w[7:0];
            exp_q.push_back({i == HL - 1, b});
        end
    endtask

    // called at posedge+1; returns at posedge+1 after start was sampled
    task automatic start_stream(input logic [15:0] w, input logic [15:0] h, input bit expect_it);
        start = 1'b1;
        img_width = w;
        img_height = h;
        if (expect_it) push_stream(w, h);
        @(posedge clk);
        #1;
        start = 1'b0;
        img_width = 16'($urandom);
        img_height = 16'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("acc_reach", acc_cnt >= target, 1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rom_a"}, 32'(hdr_rom_a), 0);
        chk({tag, "_data"}, hdr_data, 0);
        chk({tag, "_valid"}, hdr_valid, 0);
        chk({tag, "_last"}, hdr_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       hdr_ready = 1'b0;
            2:       hdr_ready = ($urandom_range(99) < 30);
            default: hdr_ready = 1'b1;
        endcase
    end

    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic          pbusy = 1'b0;
    logic          acc_last_prev = 1'b0;
    logic [8:0]    pbyte = '0;
    logic [AW-1:0] pa = '0;

    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
            pr = 1'b0;
            pbusy = 1'b0;
            acc_last_prev = 1'b0;
            acc_cnt = 0;
        end else begin
            chk("done_pulse", done, acc_last_prev);
            if (pv && !pr) begin
                chk("stall_valid", hdr_valid, 1);
                chk("stall_byte", {hdr_last, hdr_data}, pbyte);
            end
            if (busy && !pbusy) begin
                chk("start_addr", 32'(hdr_rom_a), 0);
                acc_cnt = 0;
            end else if (busy && hdr_rom_a != pa) begin
                chk("addr_step", 32'(hdr_rom_a), 32'(pa) + 1);
            end
            if (busy) chk("credit", (int'(hdr_rom_a) + 1 - acc_cnt) <= 2, 1);
            if (hdr_valid && hdr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected none", {hdr_last, hdr_data});
                end else begin
                    chk("byte", {hdr_last, hdr_data}, exp_q.pop_front());
                end
                acc_cnt++;
            end
            acc_last_prev = hdr_valid && hdr_ready && hdr_last;
            pv = hdr_valid;
            pr = hdr_ready;
            pbyte = {hdr_last, hdr_data};
            pa = hdr_rom_a;
            pbusy = busy;
        end
    end

    initial begin
        fill_rom(1'b0);
        #1;
        chk_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // full stream, ready held high, with first-byte latency checks
        rdy_mode = 1;
        start_stream(16'd640, 16'd480, 1'b1);
        chk("e0_rom_a", 32'(hdr_rom_a), 0);
        chk("e0_busy", busy, 1);
        @(posedge clk);
        #1;
        chk("e1_valid", hdr_valid, 0);
        @(posedge clk);
        #1;
        chk("e2_valid", hdr_valid, 1);
        chk("e2_data", hdr_data, rom[0]);
        wait_done("full_done", 3000);
        chk("full_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk("full_busy_off", busy, 0);

        // same stream under 30% random backpressure
        rdy_mode = 2;
        start_stream(16'd640, 16'd480, 1'b1);
        wait_done("bp_done", 8000);
        chk("bp_left", exp_q.size(), 0);

        // random ROM contents and dimensions
        fill_rom(1'b1);
        rdy_mode = ($urandom_range(1)) ? 2 : 1;
        start_stream(16'($urandom), 16'($urandom), 1'b1);
        wait_done("rnd_done", 8000);
        chk("rnd_left", exp_q.size(), 0);

        // stall from start: only two reads, head shows ROM[0]
        rdy_mode = 0;
        @(posedge clk);
        #1;
        start_stream(16'($urandom), 16'($urandom), 1'b1);
        repeat (19) @(posedge clk);
        #1;
        chk("stall_rom_a", 32'(hdr_rom_a), 1);
        chk("stall_head_valid", hdr_valid, 1);
        chk("stall_head_data", hdr_data, rom[0]);
        rdy_mode = 1;
        wait_done("stall_done", 3000);
        chk("stall_left", exp_q.size(), 0);

        // start while busy is ignored; start in the done cycle is taken
        rdy_mode = 2;
        start_stream(16'd320, 16'd200, 1'b1);
        wait_acc(300, 3000);
        start_stream(16'd999, 16'd777, 1'b0);
        wait_done("busy_done", 8000);
        chk("busy_left", exp_q.size(), 0);
        chk("busy_not_ext", busy, 0);
        start_stream(16'd12, 16'd34, 1'b1);
        chk("redo_busy", busy, 1);
        wait_done("redo_done", 8000);
        chk("redo_left", exp_q.size(), 0);

        // asynchronous reset mid-stream
        fill_rom(1'b0);
        rdy_mode = 1;
        @(posedge clk);
        #1;
        start_stream(16'd640, 16'd480, 1'b1);
        wait_acc(100, 1000);
        #2;
        reset = 1'b1;
        #1;
        chk_zero_outputs("mid_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        start_stream(16'd1, 16'd1, 1'b1);
        wait_done("small_done", 3000);
        chk("small_left", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
